// File: rtl/backdoor_spi_frame_ctrl.sv
// Backdoor SPI slave frame sequencer: SCK/CS_N edge detect, {RW,ADDR,DATA} framing,
// valid/ready bus command issue and mode-0 MISO read serializer. Optional: BACKDOOR_SPI_ABORT_CNT_EN.
module backdoor_spi_frame_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  output logic                  o_SYNC_EN,
  input  logic [1:0]            i_SCK_Q,
  input  logic [1:0]            i_CSN_Q,
  input  logic                  i_MOSI,
  output logic                  o_MISO,
  output logic                  o_CMD_VALID,
  input  logic                  i_CMD_READY,
  output logic                  o_CMD_WE,
  output logic [ADDR_WIDTH-1:0] o_CMD_ADDR,
  output logic [DATA_WIDTH-1:0] o_CMD_WDATA,
  input  logic [DATA_WIDTH-1:0] i_RDATA,
  output logic                  o_ERR
`ifdef BACKDOOR_SPI_ABORT_CNT_EN
  ,
  output logic [7:0]            o_ABORT_CNT
`endif
);

  localparam int CNT_W = $clog2(1 + ADDR_WIDTH + DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(ADDR_WIDTH + DATA_WIDTH);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    RDREQ = 3'd2,
    RDOUT = 3'd3,
    WDATA = 3'd4,
    WRACK = 3'd5
  } state_t;

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        bit_cnt_r, bit_cnt_s;
  logic [ADDR_WIDTH-1:0]   hdr_sr_r, hdr_sr_s;
  logic [DATA_WIDTH-2:0]   dat_sr_r, dat_sr_s;
  logic [DATA_WIDTH-1:0]   tx_sr_r, tx_sr_s;
  logic                    miso_r, miso_s;
  logic                    valid_r, valid_s;
  logic                    we_r, we_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic [DATA_WIDTH-1:0]   wdata_r, wdata_s;
  logic                    err_r, err_s;
  logic                    sync_en_r;

  logic sck_rise_s, sck_fall_s, csn_fall_s, abort_s;

  assign sck_rise_s = (i_SCK_Q == 2'b01);
  assign sck_fall_s = (i_SCK_Q == 2'b10);
  assign csn_fall_s = (i_CSN_Q == 2'b10);
  // WRACK is deliberately excluded: a fully shifted write must reach the bus.
  assign abort_s    = i_CSN_Q[0] && (state_r inside {HDR, RDREQ, RDOUT, WDATA});

  // Next-state and next-output computation for the frame FSM
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    hdr_sr_s  = hdr_sr_r;
    dat_sr_s  = dat_sr_r;
    tx_sr_s   = tx_sr_r;
    miso_s    = miso_r;
    valid_s   = valid_r;
    we_s      = we_r;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    err_s     = err_r;
    if (abort_s) begin
      valid_s = 1'b0;
      err_s   = 1'b1;
      miso_s  = 1'b0;
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          miso_s = 1'b0;
          if (csn_fall_s) begin
            bit_cnt_s = '0;
            err_s     = 1'b0;
            state_s   = HDR;
          end else begin
            state_s = IDLE;
          end
        end
        HDR: begin
          if (sck_rise_s) begin
            hdr_sr_s  = {hdr_sr_r[ADDR_WIDTH-2:0], i_MOSI};
            bit_cnt_s = bit_cnt_r + CNT_INC;
            if (bit_cnt_r == HDR_LAST) begin
              // hdr_sr_r still holds RW in its MSB on the final header bit
              addr_s = {hdr_sr_r[ADDR_WIDTH-2:0], i_MOSI};
              if (hdr_sr_r[ADDR_WIDTH-1]) begin
                state_s = WDATA;
              end else begin
                valid_s = 1'b1;
                we_s    = 1'b0;
                state_s = RDREQ;
              end
            end else begin
              state_s = HDR;
            end
          end else begin
            state_s = HDR;
          end
        end
        RDREQ: begin
          if (i_CMD_READY) begin
            valid_s   = 1'b0;
            bit_cnt_s = '0;
            state_s   = RDOUT;
            if (sck_fall_s) begin
              miso_s  = i_RDATA[DATA_WIDTH-1];
              tx_sr_s = {i_RDATA[DATA_WIDTH-2:0], 1'b0};
            end else begin
              tx_sr_s = i_RDATA;
            end
          end else if (sck_fall_s) begin
            valid_s   = 1'b0;
            err_s     = 1'b1;
            miso_s    = 1'b0;
            tx_sr_s   = '0;
            bit_cnt_s = '0;
            state_s   = RDOUT;
          end else begin
            state_s = RDREQ;
          end
        end
        RDOUT: begin
          if (sck_fall_s) begin
            miso_s  = tx_sr_r[DATA_WIDTH-1];
            tx_sr_s = {tx_sr_r[DATA_WIDTH-2:0], 1'b0};
          end else if (sck_rise_s) begin
            bit_cnt_s = bit_cnt_r + CNT_INC;
            if (bit_cnt_r == RD_LAST) begin
              miso_s  = 1'b0;
              state_s = IDLE;
            end else begin
              state_s = RDOUT;
            end
          end else begin
            state_s = RDOUT;
          end
        end
        WDATA: begin
          if (sck_rise_s) begin
            bit_cnt_s = bit_cnt_r + CNT_INC;
            dat_sr_s  = {dat_sr_r[DATA_WIDTH-3:0], i_MOSI};
            if (bit_cnt_r == WR_LAST) begin
              wdata_s = {dat_sr_r, i_MOSI};
              we_s    = 1'b1;
              valid_s = 1'b1;
              state_s = WRACK;
            end else begin
              state_s = WDATA;
            end
          end else begin
            state_s = WDATA;
          end
        end
        WRACK: begin
          if (i_CMD_READY) begin
            valid_s = 1'b0;
            state_s = IDLE;
          end else begin
            state_s = WRACK;
          end
        end
        default: begin
          valid_s = 1'b0;
          miso_s  = 1'b0;
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered output update
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_r   <= IDLE;
      bit_cnt_r <= '0;
      hdr_sr_r  <= '0;
      dat_sr_r  <= '0;
      tx_sr_r   <= '0;
      miso_r    <= 1'b0;
      valid_r   <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      hdr_sr_r  <= hdr_sr_s;
      dat_sr_r  <= dat_sr_s;
      tx_sr_r   <= tx_sr_s;
      miso_r    <= miso_s;
      valid_r   <= valid_s;
      we_r      <= we_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      err_r     <= err_s;
    end
  end

  // Synchronizer enable: held off only while in reset
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      sync_en_r <= 1'b0;
    end else begin
      sync_en_r <= 1'b1;
    end
  end

`ifdef BACKDOOR_SPI_ABORT_CNT_EN
  logic [7:0] abort_cnt_r;

  // Saturating abort counter; survives frame start, cleared only by reset
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      abort_cnt_r <= 8'h00;
    end else if (abort_s && (abort_cnt_r != 8'hFF)) begin
      abort_cnt_r <= abort_cnt_r + 8'h01;
    end else begin
      abort_cnt_r <= abort_cnt_r;
    end
  end

  assign o_ABORT_CNT = abort_cnt_r;
`else
`endif

  assign o_SYNC_EN   = sync_en_r;
  assign o_MISO      = miso_r;
  assign o_CMD_VALID = valid_r;
  assign o_CMD_WE    = we_r;
  assign o_CMD_ADDR  = addr_r;
  assign o_CMD_WDATA = wdata_r;
  assign o_ERR       = err_r;

endmodule

// File: tb/tb_backdoor_spi_frame_ctrl.sv
// Scoreboard bench for backdoor_spi_frame_ctrl: directed SPI frames, a bus responder,
// and a monitor that checks bus commands and MISO words against queued expectations.
module tb_backdoor_spi_frame_ctrl;

  localparam int HALF = 6;

  logic        i_CLK = 1'b0;
  logic        i_RST;
  logic        o_SYNC_EN;
  logic [1:0]  i_SCK_Q;
  logic [1:0]  i_CSN_Q;
  logic        i_MOSI;
  logic        o_MISO;
  logic        o_CMD_VALID;
  logic        i_CMD_READY;
  logic        o_CMD_WE;
  logic [7:0]  o_CMD_ADDR;
  logic [31:0] o_CMD_WDATA;
  logic [31:0] i_RDATA;
  logic        o_ERR;
`ifdef BACKDOOR_SPI_ABORT_CNT_EN
  logic [7:0]  o_ABORT_CNT;
`endif

  backdoor_spi_frame_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .o_SYNC_EN(o_SYNC_EN),
    .i_SCK_Q(i_SCK_Q), .i_CSN_Q(i_CSN_Q), .i_MOSI(i_MOSI), .o_MISO(o_MISO),
    .o_CMD_VALID(o_CMD_VALID), .i_CMD_READY(i_CMD_READY), .o_CMD_WE(o_CMD_WE),
    .o_CMD_ADDR(o_CMD_ADDR), .o_CMD_WDATA(o_CMD_WDATA), .i_RDATA(i_RDATA),
    .o_ERR(o_ERR)
`ifdef BACKDOOR_SPI_ABORT_CNT_EN
    , .o_ABORT_CNT(o_ABORT_CNT)
`endif
  );

  always #5 i_CLK = ~i_CLK;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  cmd_t        exp_cmd_q[$];
  logic [31:0] exp_miso_q[$];
  int          checks = 0;
  int          failures = 0;
  int          ready_delay = 0;
  bit          capture_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic we, input logic [7:0] addr, input logic [31:0] wdata);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata;
    exp_cmd_q.push_back(c);
  endtask

  // Bus responder: READY rises ready_delay cycles after VALID (held high when delay is 0)
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    i_CMD_READY = 1'b0;
    forever begin
      @(negedge i_CLK);
      if (i_RST) begin
        wait_cnt = 0;
        i_CMD_READY = 1'b0;
      end else if (o_CMD_VALID) begin
        i_CMD_READY = (wait_cnt >= ready_delay);
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        i_CMD_READY = (ready_delay == 0);
      end
    end
  end

  // Monitor: command handshakes, write hold/stability, MISO words on SCK rises
  initial begin
    cmd_t        e;
    bit          prev_pending;
    logic        prev_we;
    logic [7:0]  prev_addr;
    logic [31:0] prev_wdata;
    logic [31:0] word;
    int          nbits;
    prev_pending = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_wdata = '0;
    word = '0; nbits = 0;
    forever begin
      @(posedge i_CLK);
      if (i_RST) begin
        prev_pending = 1'b0;
        nbits = 0;
      end else begin
        if (prev_pending) begin
          if (prev_we) check("wr_valid_hold", o_CMD_VALID, 1'b1);
          if (o_CMD_VALID) begin
            check("cmd_we_stable", o_CMD_WE, prev_we);
            check("cmd_addr_stable", o_CMD_ADDR, prev_addr);
            check("cmd_wdata_stable", o_CMD_WDATA, prev_wdata);
          end
        end
        if (o_CMD_VALID && i_CMD_READY) begin
          if (exp_cmd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL cmd_unexpected actual=we%0d addr %h required=no command", o_CMD_WE, o_CMD_ADDR);
          end else begin
            e = exp_cmd_q.pop_front();
            check("cmd_we", o_CMD_WE, e.we);
            check("cmd_addr", o_CMD_ADDR, e.addr);
            if (e.we) check("cmd_wdata", o_CMD_WDATA, e.wdata);
          end
        end
        prev_pending = o_CMD_VALID && !i_CMD_READY;
        prev_we = o_CMD_WE; prev_addr = o_CMD_ADDR; prev_wdata = o_CMD_WDATA;
        if (!capture_en) begin
          nbits = 0;
        end else if (i_SCK_Q == 2'b01) begin
          word = {word[30:0], o_MISO};
          nbits++;
          if (nbits == 32) begin
            nbits = 0;
            if (exp_miso_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL miso_unexpected actual=%h required=no word", word);
            end else begin
              check("miso_word", word, exp_miso_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_CLK);
  endtask

  task automatic spi_rise(input logic b);
    i_MOSI = b; i_SCK_Q = 2'b01; tick(1);
    i_SCK_Q = 2'b11; tick(HALF);
  endtask

  task automatic spi_fall();
    i_SCK_Q = 2'b10; tick(1);
    i_SCK_Q = 2'b00; tick(HALF);
  endtask

  task automatic send_bit(input logic b);
    spi_rise(b);
    spi_fall();
  endtask

  task automatic frame_start();
    i_CSN_Q = 2'b10; tick(1);
    i_CSN_Q = 2'b00; tick(2);
  endtask

  task automatic frame_end();
    i_CSN_Q = 2'b01; tick(1);
    i_CSN_Q = 2'b11; tick(3);
  endtask

  task automatic send_hdr(input logic rw, input logic [7:0] addr);
    send_bit(rw);
    for (int i = 7; i >= 0; i--) send_bit(addr[i]);
  endtask

  task automatic send_word(input logic [31:0] d, input bit last_fall);
    for (int i = 31; i >= 1; i--) send_bit(d[i]);
    spi_rise(d[0]);
    if (last_fall) spi_fall();
  endtask

  initial begin
    i_RST = 1'b1; i_SCK_Q = 2'b00; i_CSN_Q = 2'b11; i_MOSI = 1'b0; i_RDATA = '0;
    tick(3);
    check("rst_ctrl_outs", {o_SYNC_EN, o_MISO, o_CMD_VALID, o_CMD_WE, o_ERR}, 5'b0);
    check("rst_addr", o_CMD_ADDR, 8'h00);
    check("rst_wdata", o_CMD_WDATA, 32'h0);
    i_RST = 1'b0;
    tick(2);
    check("sync_en_run", o_SYNC_EN, 1'b1);

    // 1: write frame, READY held high
    ready_delay = 0;
    push_cmd(1'b1, 8'h3C, 32'hDEADBEEF);
    frame_start();
    send_hdr(1'b1, 8'h3C);
    send_word(32'hDEADBEEF, 1'b1);
    frame_end();
    check("t1_err", o_ERR, 1'b0);
    check("t1_valid_low", o_CMD_VALID, 1'b0);

    // 2: read frame, READY two cycles after VALID
    ready_delay = 2;
    i_RDATA = 32'hA5A5_0F0F;
    push_cmd(1'b0, 8'h05, 32'h0);
    exp_miso_q.push_back(32'hA5A5_0F0F);
    frame_start();
    send_hdr(1'b0, 8'h05);
    capture_en = 1'b1;
    send_word(32'hFFFF_0000, 1'b1);
    capture_en = 1'b0;
    check("t2_miso_idle", o_MISO, 1'b0);
    frame_end();
    check("t2_err", o_ERR, 1'b0);

    // 3: late read, READY never comes before first data fall
    ready_delay = 1000;
    i_RDATA = 32'hFFFF_FFFF;
    exp_miso_q.push_back(32'h0000_0000);
    frame_start();
    send_hdr(1'b0, 8'h77);
    capture_en = 1'b1;
    send_word(32'h1234_5678, 1'b1);
    capture_en = 1'b0;
    check("t3_err", o_ERR, 1'b1);
    check("t3_valid_low", o_CMD_VALID, 1'b0);
    frame_end();
    check("t3_err_sticky", o_ERR, 1'b1);

    // 4: abort after 5 header bits, then a clean write
    ready_delay = 0;
    frame_start();
    check("t4_err_cleared", o_ERR, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    frame_end();
    check("t4_abort_err", o_ERR, 1'b1);
    check("t4_abort_valid", o_CMD_VALID, 1'b0);
`ifdef BACKDOOR_SPI_ABORT_CNT_EN
    check("t4_abort_cnt", o_ABORT_CNT, 8'h01);
`endif
    push_cmd(1'b1, 8'hC3, 32'h1234_5678);
    frame_start();
    check("t4_err_clear2", o_ERR, 1'b0);
    send_hdr(1'b1, 8'hC3);
    send_word(32'h1234_5678, 1'b1);
    frame_end();
    check("t4_err_after", o_ERR, 1'b0);

    // 5: write backpressure with CS_N rising while waiting for READY
    ready_delay = 10;
    push_cmd(1'b1, 8'h5A, 32'hCAFE_F00D);
    frame_start();
    send_hdr(1'b1, 8'h5A);
    send_word(32'hCAFE_F00D, 1'b0);
    frame_end();
    check("t5_valid_held", o_CMD_VALID, 1'b1);
    spi_fall();
    tick(10);
    check("t5_valid_done", o_CMD_VALID, 1'b0);
    check("t5_err", o_ERR, 1'b0);
    ready_delay = 0;

    // 6: asynchronous reset during RDOUT, then a fresh read frame
    ready_delay = 2;
    i_RDATA = 32'h8000_0001;
    push_cmd(1'b0, 8'h99, 32'h0);
    frame_start();
    send_hdr(1'b0, 8'h99);
    check("t6_miso_msb", o_MISO, 1'b1);
    #2 i_RST = 1'b1;
    #1 check("t6_async_ctrl", {o_SYNC_EN, o_MISO, o_CMD_VALID, o_CMD_WE, o_ERR}, 5'b0);
    check("t6_async_addr", o_CMD_ADDR, 8'h00);
    @(negedge i_CLK);
    i_SCK_Q = 2'b00; i_CSN_Q = 2'b11;
    tick(2);
    i_RST = 1'b0;
    tick(2);
    check("t6_sync_en", o_SYNC_EN, 1'b1);
    i_RDATA = 32'h3C3C_1234;
    push_cmd(1'b0, 8'hE7, 32'h0);
    exp_miso_q.push_back(32'h3C3C_1234);
    frame_start();
    send_hdr(1'b0, 8'hE7);
    capture_en = 1'b1;
    send_word(32'h0, 1'b1);
    capture_en = 1'b0;
    frame_end();
    check("t6_err", o_ERR, 1'b0);
    ready_delay = 0;

`ifdef BACKDOOR_SPI_ABORT_CNT_EN
    check("cnt_after_reset", o_ABORT_CNT, 8'h00);
    for (int n = 0; n < 300; n++) begin
      frame_start();
      send_bit(1'b1);
      frame_end();
    end
    check("cnt_saturated", o_ABORT_CNT, 8'hFF);
`endif

    tick(4);
    check("cmd_queue_drained", exp_cmd_q.size(), 0);
    check("miso_queue_drained", exp_miso_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
